mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer_pkg.sv | 36 +++
 rtl/mem_sequencer.sv | 137 +++++++++++++
 tb/tb_mem_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared CPU memory-interface definitions: access size codes, sequencer
// state encodings and small helpers reused by the bus decoder.
package mem_sequencer_pkg;

    // Access width encodings carried on the CPU size bus
    localparam logic [1:0] SIZE_8  = 2'b00;
    localparam logic [1:0] SIZE_16 = 2'b01;
    localparam logic [1:0] SIZE_32 = 2'b10;

    // Sequencer state encodings
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WRITE      = 3'd1;
    localparam logic [2:0] ST_READ       = 3'd2;
    localparam logic [2:0] ST_READ_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    // Index of the last byte touched by an access of the given size
    function automatic logic [1:0] last_byte(input logic [1:0] size);
        case (size)
            SIZE_8:           return 2'd0;
            SIZE_16:          return 2'd1;
            SIZE_32, 2'b11:   return 2'd3;
            default:          return 2'd3;
        endcase
    endfunction

    // Keeps bytes 0..last of an assembled read word, zeroes the rest
    function automatic logic [31:0] byte_mask(input logic [1:0] last);
        case (last)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return '1;
        endcase
    endfunction

endpackage

// File: rtl/mem_sequencer.sv
// Splits a 32-bit CPU access into 1, 2 or 4 sequential byte accesses on an
// 8-bit synchronous RAM. All RAM-side outputs come straight from registers.
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [1:0]            size,
    input  logic                  write_enable,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [7:0]            ram_data_in,
    input  logic [7:0]            ram_data_out,
    output logic                  ram_write_enable
);

    logic [2:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            last_q, last_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rbuf_q, rbuf_d;
    logic [31:0]           data_out_q, data_out_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_wdata_q, ram_wdata_d;
    logic                  ram_we_q, ram_we_d;

    logic [1:0]            cnt_inc;
    logic [1:0]            cnt_dec;
    logic [31:0]           rd_word;

    assign cnt_inc = cnt_q + 2'd1;
    assign cnt_dec = cnt_q - 2'd1;

    // Next-state and datapath: the RAM returns a byte one edge after its
    // address, so capture in READ lags the issued address by one count and
    // READ_FLUSH picks up the final byte after the last address.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        data_out_d  = data_out_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = ram_we_q;
        rd_word     = rbuf_q;
        rd_word[{last_q, 3'b000} +: 8] = ram_data_out;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ram_addr_d  = address;
                    ram_we_d    = write_enable;
                    ram_wdata_d = data_in[7:0];
                    wdata_d     = data_in;
                    last_d      = last_byte(size);
                    cnt_d       = '0;
                    state_d     = write_enable ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (cnt_q == last_q) begin
                    ram_we_d = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d       = cnt_inc;
                    ram_addr_d  = ram_addr_q + ADDR_WIDTH'(1);
                    ram_wdata_d = wdata_q[{cnt_inc, 3'b000} +: 8];
                end
            end
            ST_READ: begin
                if (cnt_q != 2'd0) begin
                    rbuf_d[{cnt_dec, 3'b000} +: 8] = ram_data_out;
                end
                if (cnt_q == last_q) begin
                    state_d = ST_READ_FLUSH;
                end else begin
                    cnt_d      = cnt_inc;
                    ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_READ_FLUSH: begin
                rbuf_d     = rd_word;
                data_out_d = rd_word & byte_mask(last_q);
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                ram_we_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            data_out_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            data_out_q  <= data_out_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign data_out         = data_out_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign ram_address      = ram_addr_q;
    assign ram_data_in      = ram_wdata_q;
    assign ram_write_enable = ram_we_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: directed requests push expected
// completions; a negedge monitor pops and compares on every done pulse.
module tb_mem_sequencer;

    localparam int AW = 12;

    typedef struct {
        int          done_cyc;
        logic [31:0] dout;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] address = '0;
    logic [1:0]    size = '0;
    logic          write_enable = 1'b0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data_in;
    logic [7:0]    ram_data_out;
    logic          ram_write_enable;

    logic [7:0]    ram  [0:4095];
    logic [7:0]    gold [0:4095];
    bit            exp_we [0:4095];

    exp_t          sb[$];
    exp_t          e;
    int            cyc = 0;
    int            next_ok = 0;
    int            last_acc = 0;
    logic [31:0]   exp_dout = '0;
    int            checks = 0;
    int            errors = 0;

    mem_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .address(address),
        .size(size), .write_enable(write_enable), .data_in(data_in),
        .data_out(data_out), .busy(busy), .done(done),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_write_enable(ram_write_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit synchronous RAM model
    always @(posedge clk) begin
        if (ram_write_enable) ram[ram_address] <= ram_data_in;
        ram_data_out <= ram[ram_address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: write strobe against expected window, and done pulses
    always @(negedge clk) begin
        if (cyc < 4096) chk("ram_we", {31'b0, ram_write_enable}, {31'b0, exp_we[cyc]});
        if (reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_done_cyc"}, cyc, e.done_cyc);
                chk({e.name, "_data_out"}, data_out, e.dout);
                chk({e.name, "_busy"}, {31'b0, busy}, 32'd1);
            end
        end
    end

    // Issue one request at a negedge; returns at the negedge after its accept edge
    task automatic issue(input logic we, input logic [1:0] sz, input logic [11:0] ad,
                         input logic [31:0] dt, input logic [31:0] exp_rd,
                         input bit hold, input bit track, input string nm);
        int n, k, a;
        logic [11:0] ai;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        write_enable = we; size = sz; address = ad; data_in = dt; start = 1'b1;
        k = cyc;
        a = (k + 1 > next_ok) ? k + 1 : next_ok;
        repeat (a - k) @(posedge clk);
        last_acc = a;
        if (we) begin
            for (int i = 0; i < n; i++) begin
                exp_we[a + i] = 1'b1;
                ai = ad + 12'(i);
                if (track) gold[ai] = dt[8*i +: 8];
            end
        end
        if (track) begin
            if (we) sb.push_back('{a + n, exp_dout, nm});
            else begin
                sb.push_back('{a + n + 1, exp_rd, nm});
                exp_dout = exp_rd;
            end
        end
        next_ok = we ? a + n + 2 : a + n + 3;
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            address = AW'($urandom);
            data_in = $urandom;
            size = 2'($urandom);
            write_enable = 1'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] <= 8'(i) ^ 8'h5A;
            gold[i] = 8'(i) ^ 8'h5A;
        end

        #12;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_ram_address", {20'b0, ram_address}, 32'h0);
        chk("rst_ram_data_in", {24'b0, ram_data_in}, 32'h0);
        chk("rst_ram_we", {31'b0, ram_write_enable}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        next_ok = cyc + 1;

        issue(1'b1, 2'b10, 12'h010, 32'h11223344, 32'h0, 1'b0, 1'b1, "wr32");
        issue(1'b0, 2'b10, 12'h010, 32'h0, 32'h11223344, 1'b0, 1'b1, "rd32");
        issue(1'b0, 2'b00, 12'h013, 32'h0, 32'h00000011, 1'b0, 1'b1, "rd8");
        issue(1'b1, 2'b01, 12'hFFF, 32'h1234BEEF, 32'h0, 1'b0, 1'b1, "wr16_wrap");
        issue(1'b0, 2'b01, 12'hFFF, 32'h0, 32'h0000BEEF, 1'b0, 1'b1, "rd16_wrap");

        // Extra start pulses at E1 and E2 of a read must be ignored
        issue(1'b0, 2'b10, 12'h010, 32'h0, 32'h11223344, 1'b0, 1'b1, "rd32_ignore");
        start = 1'b1; write_enable = 1'b1; address = 12'h022; data_in = 32'hDEADBEEF; size = 2'b10;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0; write_enable = 1'b0;

        // Reset between E2 and E3 of a 32-bit write
        issue(1'b1, 2'b10, 12'h020, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0, "wr_reset");
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        exp_we[last_acc + 2] = 1'b0;
        exp_we[last_acc + 3] = 1'b0;
        gold[12'h020] = 8'hDD;
        gold[12'h021] = 8'hCC;
        exp_dout = '0;
        #1;
        chk("midrst_data_out", data_out, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_ram_address", {20'b0, ram_address}, 32'h0);
        chk("midrst_ram_data_in", {24'b0, ram_data_in}, 32'h0);
        chk("midrst_ram_we", {31'b0, ram_write_enable}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_ok = cyc + 1;
        issue(1'b0, 2'b00, 12'h021, 32'h0, 32'h000000CC, 1'b0, 1'b1, "rd8_after_rst");
        issue(1'b0, 2'b10, 12'h020, 32'h0, 32'h7978CCDD, 1'b0, 1'b1, "rd32_partial");

        // Back-to-back with start held high
        issue(1'b1, 2'b10, 12'h100, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1, "b2b_wr32");
        issue(1'b0, 2'b11, 12'h100, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, "b2b_rd32");
        issue(1'b1, 2'b00, 12'h200, 32'h5555553C, 32'h0, 1'b1, 1'b1, "b2b_wr8");
        issue(1'b0, 2'b01, 12'h1FF, 32'h0, 32'h00003CA5, 1'b1, 1'b1, "b2b_rd16");
        issue(1'b1, 2'b01, 12'h300, 32'h99997E81, 32'h0, 1'b1, 1'b1, "b2b_wr16");
        issue(1'b0, 2'b00, 12'h301, 32'h0, 32'h0000007E, 1'b0, 1'b1, "b2b_rd8");

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("pending_done", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4096; i++) begin
            if (ram[i] !== gold[i]) chk($sformatf("ram_%03h", i), {24'b0, ram[i]}, {24'b0, gold[i]});
        end
        chk("ram_010", {24'b0, ram[12'h010]}, 32'h44);
        chk("ram_013", {24'b0, ram[12'h013]}, 32'h11);
        chk("ram_fff", {24'b0, ram[12'hFFF]}, 32'hEF);
        chk("ram_000", {24'b0, ram[12'h000]}, 32'hBE);
        chk("ram_022", {24'b0, ram[12'h022]}, 32'h78);
        chk("ram_023", {24'b0, ram[12'h023]}, 32'h79);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
